serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial WIDTH-bit subtractor computing Difference = A − B, LSB first, one bit per clock, with a registered borrow chain. It accepts an operand pair over a valid/ready handshake and presents the full-width Difference and final Borrow over a second valid/ready handshake. Its datapath is one full-subtractor cell built from two half_subtractor instances, so it is the sequential stage that directly consumes the existing half_subtractor.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range WIDTH ≥ 1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: an operand pair is presented on A and B.
- in_ready, output, 1: block accepts an operand pair this cycle.
- A, input, WIDTH: minuend.
- B, input, WIDTH: subtrahend.
- out_valid, output, 1: Difference and Borrow hold a completed result.
- out_ready, input, 1: consumer accepts the result.
- Difference, output, WIDTH: A − B, modulo 2^WIDTH.
- Borrow, output, 1: final borrow-out; equals 1 exactly when A < B (unsigned).

## Operation
FSM states are IDLE, RUN and DONE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: capture A and B into shift registers, clear the borrow register, set the bit counter to 0, and go to RUN.
- RUN, one bit per cycle
  - a = opA[0], b = opB[0], bin = borrow register.
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
  - Shift d into the MSB of the result register (right shift), shift opA and opB right by one, load bout into the borrow register, and increment the counter.
  - The cycle that processes bit WIDTH−1 transitions to DONE.
- DONE
  - out_valid = 1; Difference = result register; Borrow = borrow register.
  - On out_ready: go to IDLE.
- Handshake rules
  - in_ready = 1 only in IDLE. in_valid in RUN or DONE is ignored and nothing is captured.
  - Outputs stay stable while out_valid && !out_ready.
- Output hold: Difference and Borrow keep the last result after the return to IDLE, until the next completion.
- Arithmetic: unsigned, modulo 2^WIDTH. Counter width is $clog2(WIDTH+1). WIDTH = 1 performs exactly one RUN cycle.
- Reset: rst is asserted at any time, including mid-RUN or in DONE. The operation aborts with no result emitted. On the next edge the block is in IDLE with the values listed under Timing.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - Difference = 0, Borrow = 0.
  - Internal shift registers, counter and borrow register = 0.
- Latency: the accept edge is E0. Bits are processed at edges E1..E_WIDTH. out_valid is high after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Completion: out_valid && out_ready at edge F returns the block to IDLE. in_ready is high after F, and the earliest next accept is at edge F+1.
- Minimum spacing between accepts is WIDTH+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Package serial_subtractor_pkg holds:
  - the state enum typedef: IDLE, RUN, DONE;
  - the state encoding localparams.
- Sub-module full_subtractor: combinational, ports a, b, bin, d, bout. It is built from two half_subtractor instances plus an OR of their borrows, and is instantiated once in the datapath.
- Top level holds the FSM, the operand/result shift registers, the borrow register and the counter.

## Test plan
All scenarios use WIDTH = 8 unless stated.
- A = 0x35, B = 0x12 → Difference 0x23, Borrow 0, with out_valid 8 cycles after accept.
- A = 0x12, B = 0x35 → Difference 0xDD, Borrow 1.
- A = 0x00, B = 0x01 → Difference 0xFF, Borrow 1. A = 0xFF, B = 0xFF → Difference 0x00, Borrow 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, Difference and Borrow stay constant. Assert in_valid with A = 0x01 during RUN and DONE → not captured. After out_ready, the next result matches the next accepted pair.
- Reset: assert rst during the 3rd RUN cycle → next cycle in IDLE with in_ready 1, out_valid 0, Difference 0x00 and Borrow 0. A fresh 0x80 − 0x01 → 0x7F, Borrow 0.
- WIDTH = 1 build: all four input pairs → half_subtractor truth table (0,0 → 0,0; 0,1 → 1,1; 1,0 → 1,0; 1,1 → 0,0), each with 1-cycle latency.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding for the bit-serial subtractor
package serial_subtractor_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand and result handshakes of the serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Difference;
   logic             Borrow;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Difference, Borrow
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Difference, Borrow
   );

endinterface

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor built from two half subtractors
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d_ab;
   logic b_ab;
   logic b_bin;

   half_subtractor u_hs_ab (
      .a    (a),
      .b    (b),
      .d    (d_ab),
      .bout (b_ab)
   );

   // Second stage subtracts the incoming borrow from the partial difference.
   half_subtractor u_hs_bin (
      .a    (d_ab),
      .b    (bin),
      .d    (d),
      .bout (b_bin)
   );

   assign bout = b_ab | b_bin;

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - one-bit half subtractor, d = a - b with borrow-out
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial A - B with valid/ready operand and result handshakes
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   import serial_subtractor_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bo_q, bo_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic             d_bit;
   logic             bout_bit;

   full_subtractor u_fs (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (bout_bit)
   );

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bo_d     = bo_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               opa_d    = bus.A;
               opb_d    = bus.B;
               res_d    = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = d_bit;
            opa_d            = opa_q >> 1;
            opb_d            = opb_q >> 1;
            borrow_d         = bout_bit;
            cnt_d            = cnt_q + CW'(1);
            // Visible outputs only change on completion so they hold the previous result meanwhile.
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               diff_d  = res_d;
               bo_d    = bout_bit;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         res_q       <= '0;
         borrow_q    <= 1'b0;
         cnt_q       <= '0;
         diff_q      <= '0;
         bo_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         res_q       <= res_d;
         borrow_q    <= borrow_d;
         cnt_q       <= cnt_d;
         diff_q      <= diff_d;
         bo_q        <= bo_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.Difference = diff_q;
   assign bus.Borrow     = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8 and WIDTH 1
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec8_t;

   typedef struct {
      logic a;
      logic b;
      logic d;
      logic bo;
   } vec1_t;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain modular arithmetic and unsigned compare.
   function automatic logic [7:0] ref_diff(input int a, input int b);
      int r;
      r = ((a - b) % 256 + 256) % 256;
      return 8'(r);
   endfunction

   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ed, input logic eb, input string name);
      int cyc;
      cyc = 0;
      while (!bus8.in_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      bus8.in_valid = 1'b1;
      bus8.A        = a;
      bus8.B        = b;
      tick();
      bus8.in_valid = 1'b0;
      check({name, " in_ready_in_run"}, 32'(bus8.in_ready), 32'd0);
      cyc = 0;
      while (!bus8.out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'd8);
      check({name, " difference"}, 32'(bus8.Difference), 32'(ed));
      check({name, " borrow"}, 32'(bus8.Borrow), 32'(eb));
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      check({name, " out_valid_after"}, 32'(bus8.out_valid), 32'd0);
      check({name, " in_ready_after"}, 32'(bus8.in_ready), 32'd1);
   endtask

   task automatic op1(input logic a, input logic b, input logic ed, input logic eb,
                      input string name);
      int cyc;
      bus1.in_valid = 1'b1;
      bus1.A        = a;
      bus1.B        = b;
      tick();
      bus1.in_valid = 1'b0;
      cyc = 0;
      while (!bus1.out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'd1);
      check({name, " difference"}, 32'(bus1.Difference), 32'(ed));
      check({name, " borrow"}, 32'(bus1.Borrow), 32'(eb));
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec8_t tab8[5];
      vec1_t tab1[4];
      logic [7:0] hold_d;
      logic       hold_b;
      int ra, rb, cyc;

      tab8[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
      tab8[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
      tab8[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      tab8[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tab8[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
      tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
      tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.A = '0; bus8.B = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.A = '0; bus1.B = '0;
      tick();
      tick();
      rst = 1'b0;

      check("reset in_ready", 32'(bus8.in_ready), 32'd1);
      check("reset out_valid", 32'(bus8.out_valid), 32'd0);
      check("reset difference", 32'(bus8.Difference), 32'd0);
      check("reset borrow", 32'(bus8.Borrow), 32'd0);
      check("reset w1 in_ready", 32'(bus1.in_ready), 32'd1);
      check("reset w1 out_valid", 32'(bus1.out_valid), 32'd0);

      for (int i = 0; i < 5; i++)
         op8(tab8[i].a, tab8[i].b, tab8[i].d, tab8[i].bo, $sformatf("vec%0d", i));

      for (int i = 0; i < 4; i++)
         op1(tab1[i].a, tab1[i].b, tab1[i].d, tab1[i].bo, $sformatf("w1 vec%0d", i));

      for (int i = 0; i < 24; i++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         op8(8'(ra), 8'(rb), ref_diff(ra, rb), (ra < rb), $sformatf("rand%0d", i));
      end

      // Backpressure, with stray in_valid throughout RUN and DONE.
      bus8.in_valid = 1'b1; bus8.A = 8'h5A; bus8.B = 8'h3C;
      tick();
      bus8.A = 8'h01; bus8.B = 8'h00;
      cyc = 0;
      while (!bus8.out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check("bp latency", 32'(cyc), 32'd8);
      hold_d = ref_diff(32'h5A, 32'h3C);
      hold_b = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("bp stall%0d out_valid", i), 32'(bus8.out_valid), 32'd1);
         check($sformatf("bp stall%0d difference", i), 32'(bus8.Difference), 32'(hold_d));
         check($sformatf("bp stall%0d borrow", i), 32'(bus8.Borrow), 32'(hold_b));
         check($sformatf("bp stall%0d in_ready", i), 32'(bus8.in_ready), 32'd0);
      end
      bus8.out_ready = 1'b1;
      bus8.in_valid  = 1'b0;
      tick();
      bus8.out_ready = 1'b0;
      check("bp released out_valid", 32'(bus8.out_valid), 32'd0);
      check("bp hold difference", 32'(bus8.Difference), 32'(hold_d));
      check("bp hold borrow", 32'(bus8.Borrow), 32'(hold_b));
      op8(8'h07, 8'h09, ref_diff(7, 9), 1'b1, "bp next");

      // Reset during the third RUN cycle.
      bus8.in_valid = 1'b1; bus8.A = 8'hAA; bus8.B = 8'h11;
      tick();
      bus8.in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun rst in_ready", 32'(bus8.in_ready), 32'd1);
      check("midrun rst out_valid", 32'(bus8.out_valid), 32'd0);
      check("midrun rst difference", 32'(bus8.Difference), 32'd0);
      check("midrun rst borrow", 32'(bus8.Borrow), 32'd0);
      cyc = 0;
      while (cyc < 10) begin
         tick();
         if (bus8.out_valid) break;
         cyc++;
      end
      check("midrun rst no result", 32'(bus8.out_valid), 32'd0);
      op8(8'h80, 8'h01, 8'h7F, 1'b0, "after rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
